eth_tx_sched: RTL and testbench

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

---
 rtl/eth_tx_sched.sv | 137 +++++++++++++
 tb/tb_eth_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-requester round-robin RMII transmitter with preamble/SFD insertion, underrun drain and IFG timing.
module eth_tx_sched #(
    parameter int PRE_BYTES = 7,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_vld,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    input  logic       req1_vld,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req0_rdy,
    output logic       req1_rdy,
    output logic [1:0] eth_txd,
    output logic       eth_tx_en,
    output logic       busy,
    output logic       grant,
    output logic       underrun
);
    localparam int PRE_N = PRE_BYTES * 4;
    localparam int IFG_N = IFG_BYTES * 4;
    localparam int MAX_N = PRE_N > IFG_N ? PRE_N : IFG_N;
    localparam int CW = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic lastb_q, lastb_d, grant_q, grant_d, lastg_q, lastg_d, en_q, en_d;
    logic [1:0] txd_q, txd_d;
    logic g_vld, g_last, g_rdy, byte_end, hs_slot;
    logic [7:0] g_data;

    assign g_vld = grant_q ? req1_vld : req0_vld;
    assign g_last = grant_q ? req1_last : req0_last;
    assign g_data = grant_q ? req1_data : req0_data;
    assign byte_end = cnt_q == CW'(3);
    // The next byte is fetched on the last dibit so it is on the wire the following cycle.
    assign hs_slot = byte_end && (state_q == SFD || (state_q == DATA && !lastb_q));
    assign g_rdy = hs_slot || (state_q == DRAIN && g_vld);
    assign req0_rdy = g_rdy && !grant_q;
    assign req1_rdy = g_rdy && grant_q;
    assign underrun = hs_slot && !g_vld;
    assign busy = state_q != IDLE;
    assign grant = grant_q;
    assign eth_txd = txd_q;
    assign eth_tx_en = en_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + CW'(1);
        byte_d = byte_q;
        lastb_d = lastb_q;
        grant_d = grant_q;
        lastg_d = lastg_q;
        txd_d = 2'b00;
        en_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0_vld || req1_vld) begin
                    grant_d = (req0_vld && req1_vld) ? !lastg_q : req1_vld;
                    lastg_d = grant_d;
                    state_d = PRE;
                    txd_d = 2'b01;
                    en_d = 1'b1;
                end
            end
            PRE: begin
                en_d = 1'b1;
                txd_d = 2'b01;
                if (cnt_q == CW'(PRE_N - 1)) begin
                    state_d = SFD;
                    cnt_d = '0;
                end
            end
            SFD, DATA: begin
                en_d = 1'b1;
                txd_d = state_q == SFD ? (cnt_q == CW'(2) ? 2'b11 : 2'b01)
                                       : byte_q[{cnt_q[1:0] + 2'd1, 1'b0} +: 2];
                if (byte_end) begin
                    cnt_d = '0;
                    if (state_q == DATA && lastb_q) begin
                        state_d = IFG;
                        en_d = 1'b0;
                        txd_d = 2'b00;
                    end else if (g_vld) begin
                        state_d = DATA;
                        byte_d = g_data;
                        lastb_d = g_last;
                        txd_d = g_data[1:0];
                    end else begin
                        state_d = DRAIN;
                        en_d = 1'b0;
                        txd_d = 2'b00;
                    end
                end
            end
            DRAIN: begin
                cnt_d = '0;
                state_d = (g_vld && g_last) ? IFG : DRAIN;
            end
            IFG: begin
                if (cnt_q == CW'(IFG_N - 1)) begin
                    state_d = IDLE;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            byte_q <= '0;
            lastb_q <= 1'b0;
            grant_q <= 1'b0;
            lastg_q <= 1'b1;
            txd_q <= 2'b00;
            en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            byte_q <= byte_d;
            lastb_q <= lastb_d;
            grant_q <= grant_d;
            lastg_q <= lastg_d;
            txd_q <= txd_d;
            en_q <= en_d;
        end
    end
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed checks of framing, arbitration, underrun, reset and IFG timing.
module tb_eth_tx_sched;
    logic clk = 0, rst = 0;
    always #10 clk = ~clk;

    logic r0v = 0, r1v = 0, r0l = 0, r1l = 0, r0r, r1r;
    logic [7:0] r0d = 0, r1d = 0;
    logic [1:0] txd;
    logic en, busy, gnt, und;

    logic sv = 0, sl = 0, sr, sen, sbusy, sgnt, sund, sr1;
    logic [7:0] sd = 0;
    logic [1:0] stxd;

    eth_tx_sched dut (
        .clk(clk), .reset(rst),
        .req0_vld(r0v), .req0_data(r0d), .req0_last(r0l),
        .req1_vld(r1v), .req1_data(r1d), .req1_last(r1l),
        .req0_rdy(r0r), .req1_rdy(r1r),
        .eth_txd(txd), .eth_tx_en(en), .busy(busy), .grant(gnt), .underrun(und)
    );

    eth_tx_sched #(.PRE_BYTES(1), .IFG_BYTES(2)) dut_s (
        .clk(clk), .reset(rst),
        .req0_vld(sv), .req0_data(sd), .req0_last(sl),
        .req1_vld(1'b0), .req1_data(8'h00), .req1_last(1'b0),
        .req0_rdy(sr), .req1_rdy(sr1),
        .eth_txd(stxd), .eth_tx_en(sen), .busy(sbusy), .grant(sgnt), .underrun(sund)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [8:0] q0[$], q1[$];
    int pop0 = 0, pop1 = 0, gap_at1 = -1, stall1 = 0, lc = 0;
    logic [1:0] l_txd[1024];
    bit l_en[1024], l_busy[1024], l_gnt[1024], l_und[1024], l_r0[1024], l_r1[1024];

    // Requester model and per-cycle output log for the default-parameter DUT.
    always @(negedge clk) begin
        r0v = q0.size() > 0;
        r0d = r0v ? q0[0][7:0] : 8'h00;
        r0l = r0v ? q0[0][8] : 1'b0;
        if (q1.size() > 0 && pop1 == gap_at1 && stall1 > 0) begin
            r1v = 0;
            stall1--;
        end else r1v = q1.size() > 0;
        r1d = r1v ? q1[0][7:0] : 8'h00;
        r1l = r1v ? q1[0][8] : 1'b0;
        #1;
        if (lc < 1024) begin
            l_txd[lc] = txd; l_en[lc] = en; l_busy[lc] = busy;
            l_gnt[lc] = gnt; l_und[lc] = und; l_r0[lc] = r0r; l_r1[lc] = r1r;
        end
        lc++;
        if (r0v && r0r) begin void'(q0.pop_front()); pop0++; end
        if (r1v && r1r) begin void'(q1.pop_front()); pop1++; end
    end

    function automatic int sig(int sel, int i);
        if (i < 0 || i >= lc || i >= 1024) return -1;
        case (sel)
            0: return int'(l_r0[i]);
            1: return int'(l_r1[i]);
            2: return int'(l_und[i]);
            3: return int'(l_en[i]);
            4: return int'(l_busy[i]);
            default: return int'(l_gnt[i]);
        endcase
    endfunction

    function automatic int count_sig(int sel, int a, int b);
        int n = 0;
        for (int i = a; i < b; i++) if (sig(sel, i) == 1) n++;
        return n;
    endfunction

    function automatic int first_sig(int sel, int from);
        for (int i = from; i < lc && i < 1024; i++) if (sig(sel, i) == 1) return i;
        return -1;
    endfunction

    function automatic int last_sig(int sel);
        int r = -1;
        for (int i = 0; i < lc && i < 1024; i++) if (sig(sel, i) == 1) r = i;
        return r;
    endfunction

    function automatic int run_len(int s);
        int n = 0;
        if (s < 0) return 0;
        while (sig(3, s + n) == 1) n++;
        return n;
    endfunction

    task automatic cmp_frame(input string tag, input int s, input int pre, input logic [39:0] b, input int n);
        int mism = 0, k;
        logic [1:0] e;
        logic [7:0] by;
        for (int i = 0; i < pre * 4 + 4 + n * 4; i++) begin
            k = i - pre * 4 - 4;
            if (i < pre * 4) e = 2'b01;
            else if (k < 0) e = (k == -1) ? 2'b11 : 2'b01;
            else begin
                by = b[8 * (k / 4) +: 8];
                e = by[2 * (k % 4) +: 2];
            end
            if (s < 0 || s + i >= 1024 || s + i >= lc || l_txd[s + i] !== e || !l_en[s + i]) mism++;
        end
        check(tag, mism, 0);
    endtask

    task automatic push(input int r, input logic [39:0] b, input int n);
        logic [8:0] w;
        for (int i = 0; i < n; i++) begin
            w = {i == n - 1, b[8 * i +: 8]};
            if (r == 1) q1.push_back(w); else q0.push_back(w);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #3 rst = 1;
        q0.delete(); q1.delete(); pop0 = 0; pop1 = 0;
        @(negedge clk); #3 rst = 0;
    endtask

    task automatic start_log();
        @(posedge clk);
        lc = 0;
    endtask

    initial begin
        int s, s2, s3, u;
        bit took;
        bit s_en[30], s_busy[30], s_rdy[30];
        logic [1:0] s_txd[30];
        logic [1:0] e;
        int mism;

        #1 rst = 1;
        @(negedge clk); #3;
        check("reset_outs", int'({en, txd, busy, gnt, und, r0r, r1r}), 0);
        check("reset_outs_s", int'({sen, stxd, sbusy, sgnt, sund, sr}), 0);
        @(negedge clk); #3 rst = 0;

        // Small-parameter instance: single 0xFF byte frame.
        took = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #2;
            if (i == 0) begin sv = 1; sd = 8'hff; sl = 1; end
            else if (took) sv = 0;
            #1;
            s_en[i] = sen; s_txd[i] = stxd; s_busy[i] = sbusy; s_rdy[i] = sr;
            took = sv & sr;
        end
        mism = 0;
        s = -1;
        for (int i = 29; i >= 0; i--) if (s_rdy[i]) s = i;
        check("s_rdy_at", s, 8);
        s = 0;
        for (int i = 0; i < 30; i++) s += int'(s_rdy[i]);
        check("s_rdy_count", s, 1);
        for (int i = 0; i < 30; i++) begin
            e = (i == 8 || (i >= 9 && i <= 12)) ? 2'b11 : (i >= 1 && i <= 7) ? 2'b01 : 2'b00;
            if (s_txd[i] !== e || s_en[i] !== (i >= 1 && i <= 12)) mism++;
        end
        check("s_stream", mism, 0);
        check("s_busy_ifg_end", int'(s_busy[20]), 1);
        check("s_busy_idle", int'(s_busy[21]), 0);

        // Basic 5-byte frame from req0.
        start_log();
        push(0, 40'he5d4c3b2a1, 5);
        repeat (130) @(posedge clk);
        s = first_sig(3, 0);
        check("a_start", s, 1);
        check("a_en_len", run_len(s), 52);
        cmp_frame("a_dibits", s, 7, 40'he5d4c3b2a1, 5);
        check("a_first_rdy", first_sig(0, 0), s + 31);
        check("a_rdy0_count", count_sig(0, 0, lc), 5);
        check("a_rdy1_count", count_sig(1, 0, lc), 0);
        check("a_underrun", count_sig(2, 0, lc), 0);
        check("a_ifg_en", count_sig(3, s + 52, s + 100), 0);
        check("a_busy_ifg_end", sig(4, s + 99), 1);
        check("a_busy_idle", sig(4, s + 100), 0);
        check("a_grant", sig(5, s), 0);

        // Simultaneous requests after reset: req0 first, then req1.
        pulse_reset();
        start_log();
        push(0, 40'h2211, 2);
        push(1, 40'h4433, 2);
        repeat (220) @(posedge clk);
        s = first_sig(3, 0);
        check("b_start0", s, 1);
        check("b_len0", run_len(s), 40);
        check("b_grant0", sig(5, s), 0);
        cmp_frame("b_dibits0", s, 7, 40'h2211, 2);
        s2 = first_sig(3, s + 40);
        check("b_start1", s2, 90);
        check("b_grant1", sig(5, s2), 1);
        check("b_len1", run_len(s2), 40);
        cmp_frame("b_dibits1", s2, 7, 40'h4433, 2);
        check("b_rdy1_early", count_sig(1, 0, s2), 0);
        check("b_rdy0_count", count_sig(0, 0, lc), 2);
        check("b_rdy1_count", count_sig(1, 0, lc), 2);

        // Round robin without reset; req0 waits through the IFG.
        start_log();
        push(0, 40'h55, 1);
        repeat (5) @(posedge clk);
        push(0, 40'h66, 1);
        push(1, 40'h77, 1);
        repeat (280) @(posedge clk);
        s = first_sig(3, 0);
        check("c_grant0", sig(5, s), 0);
        cmp_frame("c_dibits0", s, 7, 40'h55, 1);
        s2 = first_sig(3, s + 36);
        check("c_start1", s2, s + 36 + 49);
        check("c_grant1", sig(5, s2), 1);
        cmp_frame("c_dibits1", s2, 7, 40'h77, 1);
        check("c_ifg_rdy0", count_sig(0, s + 36, s2), 0);
        check("c_ifg_en", count_sig(3, s + 36, s2), 0);
        s3 = first_sig(3, s2 + 36);
        check("c_start2", s3, s2 + 36 + 49);
        check("c_grant2", sig(5, s3), 0);
        cmp_frame("c_dibits2", s3, 7, 40'h66, 1);

        // Underrun on the third byte of a req1 frame.
        pulse_reset();
        start_log();
        gap_at1 = 2;
        stall1 = 10;
        push(1, 40'h0504030201, 5);
        repeat (130) @(posedge clk);
        gap_at1 = -1;
        s = first_sig(3, 0);
        u = s + 39;
        check("d_start", s, 1);
        check("d_grant", sig(5, s), 1);
        check("d_en_len", run_len(s), 40);
        cmp_frame("d_dibits", s, 7, 40'h0201, 2);
        check("d_underrun_count", count_sig(2, 0, lc), 1);
        check("d_underrun_at", first_sig(2, 0), u);
        check("d_drain_en", count_sig(3, u + 1, lc), 0);
        check("d_rdy1_count", count_sig(1, 0, lc), 6);
        check("d_last_accept", last_sig(1), u + 9);
        check("d_busy_ifg_end", sig(4, u + 57), 1);
        check("d_busy_idle", sig(4, u + 58), 0);

        // Asynchronous reset in the middle of DATA, then a clean frame.
        pulse_reset();
        start_log();
        push(0, 40'hc3b2a1, 3);
        repeat (40) @(posedge clk);
        @(negedge clk); #3;
        check("e_pre_en", int'(en), 1);
        rst = 1;
        #1;
        check("e_rst_outs", int'({en, txd, busy, gnt, und, r0r, r1r}), 0);
        q0.delete(); pop0 = 0;
        @(negedge clk); #3 rst = 0;
        start_log();
        push(0, 40'hc3b2a1, 3);
        repeat (110) @(posedge clk);
        s = first_sig(3, 0);
        check("e_start", s, 1);
        check("e_en_len", run_len(s), 44);
        cmp_frame("e_dibits", s, 7, 40'hc3b2a1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
